// File: rtl/chip8_pkg.sv
// Shared types for the CHIP-8 keypad path: key index width and the FX0A wait FSM states.
package chip8_pkg;
    localparam int NUM_KEYS = 16;
    localparam int KEY_W    = 4;

    typedef logic [KEY_W-1:0] key_idx_t;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_ARMED,
        KP_HELD,
        KP_DONE
    } kp_state_t;
endpackage

// File: rtl/chip8_lsb_enc16.sv
// Combinational 16->4 priority encoder: index of the lowest set bit, with a valid flag.
module chip8_lsb_enc16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        vld_o
);
    always_comb begin
        idx_o = 4'd0;
        vld_o = |vec_i;
        // Scan downward so the lowest set bit is the last (winning) assignment.
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) idx_o = 4'(i);
        end
    end
endmodule

// File: rtl/chip8_keypad_ctrl.sv
// Keypad front end for the CHIP-8 CPU: registered key-state vector for EX9E/EXA1 and
// the FX0A press-then-release wait handshake returning a single key code.
module chip8_keypad_ctrl #(
    parameter int NUM_KEYS    = 16,
    parameter int KEY_ACT_LOW = 0
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [NUM_KEYS-1:0] key_db_i,
    output logic [NUM_KEYS-1:0] key_state_o,
    output logic                any_key_o,
    input  logic                wait_req_i,
    input  logic                wait_cancel_i,
    output logic                wait_busy_o,
    output logic                key_valid_o,
    output logic [3:0]          key_code_o,
    input  logic                key_ack_i
);
    import chip8_pkg::*;

    logic [NUM_KEYS-1:0] k_in, press, cand;
    logic [NUM_KEYS-1:0] key_state_q, mask_q, mask_d;
    logic                any_key_q, wait_busy_q;
    logic                key_valid_q, key_valid_d;
    key_idx_t            cap_q, cap_d, key_code_q, key_code_d;
    key_idx_t            enc_idx;
    logic                enc_vld;
    kp_state_t           state_q, state_d;

    assign k_in  = (KEY_ACT_LOW != 0) ? ~key_db_i : key_db_i;
    assign press = k_in & ~key_state_q;
    // Keys that were down when the wait started only count after they have been released.
    assign cand  = press & ~mask_q;

    chip8_lsb_enc16 u_enc (
        .vec_i (cand),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cap_d       = cap_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        if (wait_cancel_i && (state_q != KP_IDLE)) begin
            state_d     = KP_IDLE;
            key_valid_d = 1'b0;
            mask_d      = '0;
        end else begin
            case (state_q)
                KP_IDLE: begin
                    if (wait_req_i) begin
                        state_d = KP_ARMED;
                        mask_d  = key_state_q | k_in;
                    end
                end
                KP_ARMED: begin
                    mask_d = mask_q & k_in;
                    if (enc_vld) begin
                        state_d = KP_HELD;
                        cap_d   = enc_idx;
                    end
                end
                KP_HELD: begin
                    if (!k_in[cap_q]) begin
                        state_d     = KP_DONE;
                        key_valid_d = 1'b1;
                        key_code_d  = cap_q;
                    end
                end
                KP_DONE: begin
                    if (key_ack_i) begin
                        state_d     = KP_IDLE;
                        key_valid_d = 1'b0;
                    end
                end
                default: state_d = KP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            key_state_q <= '0;
            any_key_q   <= 1'b0;
            state_q     <= KP_IDLE;
            wait_busy_q <= 1'b0;
            mask_q      <= '0;
            cap_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_state_q <= k_in;
            any_key_q   <= |k_in;
            state_q     <= state_d;
            wait_busy_q <= (state_d != KP_IDLE);
            mask_q      <= mask_d;
            cap_q       <= cap_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_state_o = key_state_q;
    assign any_key_o   = any_key_q;
    assign wait_busy_o = wait_busy_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
endmodule

// File: tb/tb_chip8_keypad_ctrl.sv
// Scoreboard bench for chip8_keypad_ctrl: directed scenarios plus randomized FX0A waits.
module tb_chip8_keypad_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] key_db = 16'h0000;
    logic        wait_req = 1'b0, wait_cancel = 1'b0, key_ack = 1'b0;
    logic [15:0] key_state;
    logic        any_key, wait_busy, key_valid;
    logic [3:0]  key_code;

    chip8_keypad_ctrl #(.NUM_KEYS(16), .KEY_ACT_LOW(0)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .key_db_i      (key_db),
        .key_state_o   (key_state),
        .any_key_o     (any_key),
        .wait_req_i    (wait_req),
        .wait_cancel_i (wait_cancel),
        .wait_busy_o   (wait_busy),
        .key_valid_o   (key_valid),
        .key_code_o    (key_code),
        .key_ack_i     (key_ack)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] ks_exp;
    logic        kv_prev = 1'b0;
    logic [3:0]  code_prev = 4'h0;
    logic [3:0]  e_code;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Key state is simply the input level one clock earlier.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ks_exp <= 16'h0000;
        else          ks_exp <= key_db;
    end

    // Monitor: checks the key-state mirror every cycle and pops the scoreboard on each result.
    always @(negedge clk) begin
        chk("key_state", 32'(key_state), 32'(ks_exp));
        chk("any_key", 32'(any_key), 32'(|ks_exp));
        if (key_valid && !kv_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_key_valid: got key_code %0h, required no result (t=%0t)",
                         key_code, $time);
            end else begin
                e_code = exp_q.pop_front();
                chk("key_code", 32'(key_code), 32'(e_code));
            end
        end else if (key_valid && kv_prev) begin
            chk("key_code_stable", 32'(key_code), 32'(code_prev));
        end
        kv_prev   <= key_valid;
        code_prev <= key_code;
    end

    task automatic req_pulse();
        wait_req = 1'b1;
        step();
        wait_req = 1'b0;
    endtask

    task automatic finish_wait(input string nm);
        int cyc = 0;
        while (!key_valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk({nm, "_valid_seen"}, 32'(key_valid), 32'd1);
        key_ack = 1'b1;
        step();
        key_ack = 1'b0;
        chk({nm, "_busy_after_ack"}, 32'(wait_busy), 32'd0);
        chk({nm, "_valid_after_ack"}, 32'(key_valid), 32'd0);
    endtask

    // Reference: first press after the wait starts that is not a key already held at the start
    // (unless that key has been seen released since); lowest index among same-cycle presses.
    function automatic logic [4:0] model_code(input logic [15:0] s[$]);
        for (int t = 1; t < s.size(); t++) begin
            for (int b = 0; b < 16; b++) begin
                if (s[t][b] && !s[t-1][b]) begin
                    logic counted = !s[0][b];
                    for (int u = 1; u < t; u++) if (!s[u][b]) counted = 1'b1;
                    if (counted) return {1'b1, 4'(b)};
                end
            end
        end
        return 5'd0;
    endfunction

    initial begin
        logic [15:0] tr[$];
        logic [4:0]  m;
        logic [15:0] v;

        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] tr[$];
        logic [4:0]  m;
        logic [15:0] v;
        int          len, r, hold;

        // 1: reset with every key down
        key_db = 16'hFFFF;
        step(); step();
        chk("rst_key_state", 32'(key_state), 32'h0);
        chk("rst_any_key", 32'(any_key), 32'h0);
        chk("rst_wait_busy", 32'(wait_busy), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);
        reset_n = 1'b1;
        step();
        chk("post_rst_key_state", 32'(key_state), 32'hFFFF);
        chk("post_rst_any_key", 32'(any_key), 32'h1);
        key_db = 16'h0000;
        step(); step();

        // 2: basic wait, exact latency
        req_pulse();
        chk("basic_busy", 32'(wait_busy), 32'h1);
        step();
        key_db = 16'h1 << 10;
        exp_q.push_back(4'hA);
        repeat (5) step();
        chk("basic_no_early_valid", 32'(key_valid), 32'h0);
        key_db = 16'h0000;
        step();
        chk("basic_valid", 32'(key_valid), 32'h1);
        chk("basic_code", 32'(key_code), 32'hA);
        step(); step();
        chk("basic_valid_held", 32'(key_valid), 32'h1);
        finish_wait("basic");

        // 3: pre-held key masking
        key_db = 16'h1 << 3;
        step(); step();
        req_pulse();
        key_db = (16'h1 << 3) | (16'h1 << 7);
        exp_q.push_back(4'h7);
        step(); step();
        key_db = 16'h1 << 3;
        step();
        finish_wait("mask7");
        req_pulse();
        key_db = 16'h0000;
        step();
        key_db = 16'h1 << 3;
        exp_q.push_back(4'h3);
        step();
        key_db = 16'h0000;
        step();
        finish_wait("mask3");

        // 4: simultaneous presses
        req_pulse();
        key_db = 16'h0120;
        exp_q.push_back(4'h5);
        step();
        key_db = 16'h0000;
        step();
        finish_wait("simul");

        // 5: cancel while HELD, then cancel together with ack in DONE
        req_pulse();
        key_db = 16'h1 << 2;
        step(); step();
        wait_cancel = 1'b1;
        step();
        wait_cancel = 1'b0;
        chk("cancel_busy", 32'(wait_busy), 32'h0);
        key_db = 16'h0000;
        repeat (3) step();
        chk("cancel_no_valid", 32'(key_valid), 32'h0);
        req_pulse();
        key_db = 16'h1 << 4;
        exp_q.push_back(4'h4);
        step();
        key_db = 16'h0000;
        step();
        chk("cancel_done_valid", 32'(key_valid), 32'h1);
        wait_cancel = 1'b1;
        key_ack = 1'b1;
        step();
        wait_cancel = 1'b0;
        key_ack = 1'b0;
        chk("cancel_ack_busy", 32'(wait_busy), 32'h0);
        chk("cancel_ack_valid", 32'(key_valid), 32'h0);

        // 6: asynchronous reset while HELD
        req_pulse();
        key_db = 16'h1 << 6;
        step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(wait_busy), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        key_db = 16'h0000;
        repeat (4) step();
        chk("async_rst_no_valid", 32'(key_valid), 32'h0);
        chk("async_rst_idle", 32'(wait_busy), 32'h0);

        // Randomized waits
        for (int it = 0; it < 25; it++) begin
            tr.delete();
            v = 16'($urandom & $urandom & $urandom);
            key_db = v;
            step(); step();
            tr.push_back(v);
            len = $urandom_range(3, 10);
            for (int t = 0; t < len; t++) begin
                v = v ^ 16'($urandom & $urandom & $urandom);
                tr.push_back(v);
            end
            tr.push_back(16'h0000);
            tr.push_back(16'h0000);
            r = $urandom_range(0, 15);
            hold = $urandom_range(1, 3);
            for (int t = 0; t < hold; t++) tr.push_back(16'h1 << r);
            tr.push_back(16'h0000);
            tr.push_back(16'h0000);
            m = model_code(tr);
            if (m[4]) exp_q.push_back(m[3:0]);
            wait_req = 1'b1;
            key_db = tr[0];
            step();
            wait_req = 1'b0;
            for (int t = 1; t < tr.size(); t++) begin
                key_db = tr[t];
                step();
            end
            finish_wait("rand");
        end

        step(); step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
